// File: rtl/bus_mem_responder.sv
// Word-addressed memory slave on a shared tristate data bus.
// Writes complete in one cycle; reads insert LATENCY wait states before a one-cycle drive phase.
module bus_mem_responder #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  inout  wire  [WIDTH-1:0]      bus_data,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic                  read,
  input  logic                  write,
  output logic                  ready,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, WAIT, DRIVE, WACK} state_t;

  localparam logic [1:0] LAT = 2'(LATENCY);

  state_t                state, state_nx;
  logic [1:0]            cnt, cnt_nx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      mem [2**ADDR_WIDTH];
  logic                  drive;
  logic                  rd_req, wr_req;

  assign rd_req = read && !write;
  assign wr_req = write && !read;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (rd_req) begin
          cnt_nx   = LAT;
          state_nx = (LAT == 2'd0) ? DRIVE : WAIT;
        end else if (wr_req) begin
          state_nx = WACK;
        end
      end
      WAIT: begin
        // Any change of mind by the CPU during the wait states drops the read
        if (!rd_req) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 2'd1;
          if (cnt == 2'd1) state_nx = DRIVE;
        end
      end
      DRIVE:   state_nx = IDLE;
      WACK:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      err    <= 1'b0;
      addr_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      err   <= (state == IDLE) && read && write;
      if (state == IDLE && rd_req) addr_q <= bus_addr;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset
  always_ff @(posedge clk) begin
    if (reset && state == IDLE && wr_req) mem[bus_addr] <= bus_data;
  end

  assign ready    = (state == DRIVE) || (state == WACK);
  assign drive    = (state == DRIVE) && rd_req;
  assign bus_data = drive ? mem[addr_q] : 'z;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench: two responders (LATENCY=2 and LATENCY=0) on separate pulled-down buses.
// Stimulus pushes expected responses; a negedge monitor pops and compares them.
module tb_bus_mem_responder;

  localparam int OP_WR    = 0;
  localparam int OP_RD    = 1;
  localparam int OP_RDW   = 2;
  localparam int OP_ERR   = 3;
  localparam int OP_ABORT = 4;
  localparam int OP_RST   = 5;

  localparam int K_WACK = 0;
  localparam int K_READ = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int          dut;
    int          kind;
    int          cyc;
    logic [15:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rd, wr, oe, rdy, er;
  logic [7:0]  addr [2];
  logic [15:0] dout [2];
  tri0  [15:0] bus0;
  tri0  [15:0] bus1;

  resp_t sb [$];
  int    cyc = 0;
  int    compared = 0;
  int    failed = 0;
  logic  mon_en = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  assign bus0 = oe[0] ? dout[0] : 'z;
  assign bus1 = oe[1] ? dout[1] : 'z;

  bus_mem_responder #(.WIDTH(16), .ADDR_WIDTH(8), .LATENCY(2)) dut_l2 (
    .clk(clk), .reset(reset), .bus_data(bus0), .bus_addr(addr[0]),
    .read(rd[0]), .write(wr[0]), .ready(rdy[0]), .err(er[0])
  );

  bus_mem_responder #(.WIDTH(16), .ADDR_WIDTH(8), .LATENCY(0)) dut_l0 (
    .clk(clk), .reset(reset), .bus_data(bus1), .bus_addr(addr[1]),
    .read(rd[1]), .write(wr[1]), .ready(rdy[1]), .err(er[1])
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int d, input int k, input int c, input logic [15:0] v);
    resp_t x;
    x.dut  = d;
    x.kind = k;
    x.cyc  = c;
    x.data = v;
    sb.push_back(x);
  endtask

  // Inputs change 2ns after a rising edge, so the next edge is the acceptance edge
  task automatic applyStimulus(input int d, input int op, input logic [7:0] a, input logic [15:0] v);
    int lat;
    lat = (d == 0) ? 2 : 0;
    addr[d] = a;
    case (op)
      OP_WR: begin
        wr[d] = 1'b1; oe[d] = 1'b1; dout[d] = v;
        push(d, K_WACK, cyc + 1, 16'h0000);
        step();
        wr[d] = 1'b0; oe[d] = 1'b0;
        step();
      end
      OP_RD, OP_RDW: begin
        rd[d] = 1'b1;
        push(d, K_READ, cyc + 1 + lat, (op == OP_RD) ? v : 16'h0000);
        repeat (lat + 1) step();
        if (op == OP_RDW) wr[d] = 1'b1;
        step();
        rd[d] = 1'b0; wr[d] = 1'b0;
        step();
      end
      OP_ERR: begin
        rd[d] = 1'b1; wr[d] = 1'b1; oe[d] = 1'b1; dout[d] = v;
        push(d, K_ERR, cyc + 1, 16'h0000);
        step();
        rd[d] = 1'b0; wr[d] = 1'b0; oe[d] = 1'b0;
        step();
      end
      OP_ABORT: begin
        rd[d] = 1'b1;
        step();
        rd[d] = 1'b0;
        step();
      end
      OP_RST: begin
        rd[d] = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1; rd[d] = 1'b0;
        step();
      end
      default: step();
    endcase
  endtask

  task automatic checkOutput(input int d, input logic r, input logic e, input logic [15:0] b, input logic o);
    resp_t       x;
    logic [15:0] expb;
    expb = 16'h0000;
    if (r || e) begin
      compared++;
      if (sb.size() == 0) begin
        failed++;
        $display("[TB] FAIL resp dut%0d cycle %0d: got ready=%0b err=%0b, expected no response", d, cyc, r, e);
      end else begin
        x = sb.pop_front();
        if (x.dut != d || x.cyc != cyc || r != (x.kind != K_ERR) || e != (x.kind == K_ERR)) begin
          failed++;
          $display("[TB] FAIL resp: got dut%0d ready=%0b err=%0b cycle %0d, expected dut%0d kind=%0d cycle %0d",
                   d, r, e, cyc, x.dut, x.kind, x.cyc);
        end
        if (x.kind == K_READ) expb = x.data;
      end
    end
    if (!o) begin
      compared++;
      if (b !== expb) begin
        failed++;
        $display("[TB] FAIL bus dut%0d cycle %0d: got %h, expected %h", d, cyc, b, expb);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput(0, rdy[0], er[0], bus0, oe[0]);
      checkOutput(1, rdy[1], er[1], bus1, oe[1]);
    end
  end

  initial begin
    reset = 1'b0;
    rd = '0; wr = '0; oe = '0;
    addr[0] = 8'h00; addr[1] = 8'h00;
    dout[0] = 16'h0000; dout[1] = 16'h0000;
    step();
    mon_en = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();

    $display("[TB] LATENCY=2 responder");
    applyStimulus(0, OP_WR,    8'h05, 16'h1234);
    applyStimulus(0, OP_RD,    8'h05, 16'h1234);
    applyStimulus(0, OP_WR,    8'h00, 16'hFFFF);
    applyStimulus(0, OP_WR,    8'hFF, 16'h0001);
    applyStimulus(0, OP_RD,    8'hFF, 16'h0001);
    applyStimulus(0, OP_RD,    8'h00, 16'hFFFF);
    applyStimulus(0, OP_ERR,   8'h05, 16'hBEEF);
    applyStimulus(0, OP_RD,    8'h05, 16'h1234);
    applyStimulus(0, OP_ABORT, 8'h05, 16'h0000);
    applyStimulus(0, OP_WR,    8'h22, 16'hA5A5);
    applyStimulus(0, OP_RD,    8'h22, 16'hA5A5);
    applyStimulus(0, OP_RDW,   8'h05, 16'h0000);
    applyStimulus(0, OP_RST,   8'h05, 16'h0000);
    applyStimulus(0, OP_RD,    8'h05, 16'h1234);

    $display("[TB] LATENCY=0 responder");
    applyStimulus(1, OP_WR,    8'h05, 16'h1234);
    applyStimulus(1, OP_RD,    8'h05, 16'h1234);
    applyStimulus(1, OP_WR,    8'h7E, 16'h0F0F);
    applyStimulus(1, OP_RD,    8'h7E, 16'h0F0F);
    applyStimulus(1, OP_ERR,   8'h7E, 16'h1111);
    applyStimulus(1, OP_RD,    8'h7E, 16'h0F0F);

    repeat (4) step();
    compared++;
    if (sb.size() != 0) begin
      failed++;
      $display("[TB] FAIL pending: got %0d responses never seen, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/bus_mem_responder.md
BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the bidirectional data bus width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning the address width; internal storage is 2^ADDR_WIDTH words of WIDTH bits.
REQ-003 The block SHALL have parameter LATENCY, default 1, legal range 0..3, meaning the read wait-state count.
REQ-004 The block SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 The block SHALL have port bus_data  inout  WIDTH  shared data bus, driven by this block only during a read data phase, else high-Z.
REQ-007 The block SHALL have port bus_addr  input  ADDR_WIDTH  word address from the CPU.
REQ-008 The block SHALL have port read  input  1  CPU read request, level-sensitive.
REQ-009 The block SHALL have port write  input  1  CPU write request, level-sensitive.
REQ-010 The block SHALL have port ready  output  1  one-cycle completion strobe per accepted access.
REQ-011 The block SHALL have port err  output  1  one-cycle protocol-error strobe.

Function
REQ-012 The FSM SHALL have four states: IDLE, WAIT, DRIVE, WACK.
REQ-013 In IDLE, with write=1 and read=0 at a rising edge, the block SHALL store bus_data into mem[bus_addr] on that edge and go to WACK.
REQ-014 WACK SHALL assert ready=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-015 In IDLE, with read=1 and write=0 at a rising edge, the block SHALL latch bus_addr, load the wait counter with LATENCY, and go to WAIT; with LATENCY=0 it SHALL go directly to DRIVE.
REQ-016 In WAIT, the counter SHALL decrement once per cycle; when it reaches 0 the FSM SHALL go to DRIVE.
REQ-017 In WAIT, if read=0 or write=1, the FSM SHALL abort to IDLE without asserting ready and without driving the bus.
REQ-018 The read data phase (DRIVE) SHALL begin exactly LATENCY+1 cycles after the acceptance edge.
REQ-019 In DRIVE, the block SHALL drive bus_data with mem[latched address] and assert ready=1 for exactly one cycle, then go to IDLE.
REQ-020 bus_data SHALL be driven only when state=DRIVE, read=1 and write=0; otherwise it SHALL be high-Z, including in DRIVE when write=1.
REQ-021 In IDLE, read=1 and write=1 together SHALL assert err=1 for the following cycle, perform no access, and leave the FSM in IDLE.
REQ-022 Requests arriving in WAIT, DRIVE or WACK SHALL be ignored, except as stated in REQ-017; a request still held high on return to IDLE SHALL start a new access, so the CPU must drop its request after ready.
REQ-023 A read of an address written in an earlier completed write SHALL return the written data; no write-to-read bypass within the same cycle is required.
REQ-024 The address SHALL be used modulo 2^ADDR_WIDTH, with no out-of-range error.

Reset
REQ-025 With reset=0 at a rising edge, the FSM SHALL go to IDLE and the wait counter SHALL clear to 0.
REQ-026 With reset=0 at a rising edge, ready and err SHALL clear to 0 and bus_data SHALL go high-Z from that edge.
REQ-027 Reset asserted mid-operation (WAIT, DRIVE or WACK) SHALL cancel the access with no ready strobe.
REQ-028 Memory contents SHALL NOT be cleared by reset; a write committed before reset SHALL remain readable after reset.
REQ-029 While reset=0, all requests SHALL be ignored.

Verification (LATENCY=2 unless stated)
REQ-030 The bench SHALL cover: write 0x1234 to address 0x05 at edge t -> ready=1 in cycle t+1 only; bus_data high-Z throughout.
REQ-031 The bench SHALL cover: read address 0x05 accepted at edge t -> bus_data=0x1234 and ready=1 in cycle t+3 only, high-Z in cycles t+1..t+2 and from t+4.
REQ-032 The bench SHALL cover: LATENCY=0, read address 0x05 -> bus_data=0x1234 with ready in cycle t+1.
REQ-033 The bench SHALL cover: read accepted, then read dropped in cycle t+1 -> no ready, bus never driven, FSM back in IDLE; a new write accepted in the next cycle completes normally.
REQ-034 The bench SHALL cover: read=write=1 in IDLE -> err=1 for one cycle, no ready, mem[bus_addr] unchanged (read back to confirm).
REQ-035 The bench SHALL cover: reset=0 in cycle t+1 of a read -> no ready, bus high-Z; after release, read address 0x05 returns 0x1234.
